// File: rtl/vend_controller.sv
// Coin-operated vending controller: accumulates credit from single-cycle coin
// pulses, vends on select and returns change largest-coin-first.
module vend_controller #(
  parameter int PRICE      = 65,
  parameter int CREDIT_MAX = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       penny,
  input  logic       nickel,
  input  logic       dime,
  input  logic       quarter,
  input  logic       select,
  input  logic       cancel,
  output logic [7:0] credit,
  output logic       dispense,
  output logic       ret_quarter,
  output logic       ret_dime,
  output logic       ret_nickel,
  output logic       ret_penny,
  output logic       coin_reject,
  output logic       busy
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CREDIT   = 2'd1;
  localparam logic [1:0] S_DISPENSE = 2'd2;
  localparam logic [1:0] S_CHANGE   = 2'd3;

  localparam logic [7:0] PRICE_C = 8'(PRICE);
  localparam logic [7:0] MAX_C   = 8'(CREDIT_MAX);

  logic [1:0] state_q, state_d;
  logic [7:0] credit_q, credit_d;
  logic       dispense_q, dispense_d;
  logic       ret_q_q, ret_q_d;
  logic       ret_d_q, ret_d_d;
  logic       ret_n_q, ret_n_d;
  logic       ret_p_q, ret_p_d;
  logic       reject_q, reject_d;
  logic       busy_q, busy_d;

  logic [2:0] coin_cnt_s;
  logic       coin_any_s;
  logic [7:0] coin_val_s;
  logic [8:0] coin_sum_s;

  // Decode the coin sensor inputs into a count and a cent value.
  always_comb begin
    coin_cnt_s = {2'b00, penny} + {2'b00, nickel} + {2'b00, dime} + {2'b00, quarter};
    coin_any_s = (coin_cnt_s != 3'd0);
    case ({quarter, dime, nickel, penny})
      4'b1000: coin_val_s = 8'd25;
      4'b0100: coin_val_s = 8'd10;
      4'b0010: coin_val_s = 8'd5;
      4'b0001: coin_val_s = 8'd1;
      default: coin_val_s = 8'd0;
    endcase
    coin_sum_s = {1'b0, credit_q} + {1'b0, coin_val_s};
  end

  // Next-state, credit and pulse computation.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    dispense_d = 1'b0;
    ret_q_d    = 1'b0;
    ret_d_d    = 1'b0;
    ret_n_d    = 1'b0;
    ret_p_d    = 1'b0;
    reject_d   = 1'b0;
    case (state_q)
      S_IDLE, S_CREDIT: begin
        // Cancel with zero credit is a no-op, so a coin that cycle still counts.
        if (cancel && (credit_q != 8'd0)) begin
          state_d  = S_CHANGE;
          reject_d = coin_any_s;
        end else if (select && (credit_q >= PRICE_C)) begin
          dispense_d = 1'b1;
          credit_d   = credit_q - PRICE_C;
          state_d    = S_DISPENSE;
          reject_d   = coin_any_s;
        end else if (coin_cnt_s == 3'd1) begin
          if (coin_sum_s <= {1'b0, MAX_C}) begin
            credit_d = coin_sum_s[7:0];
            state_d  = S_CREDIT;
          end else begin
            reject_d = 1'b1;
          end
        end else begin
          reject_d = coin_any_s;
        end
      end
      S_DISPENSE: begin
        state_d  = (credit_q != 8'd0) ? S_CHANGE : S_IDLE;
        reject_d = coin_any_s;
      end
      S_CHANGE: begin
        reject_d = coin_any_s;
        if (credit_q >= 8'd25) begin
          ret_q_d  = 1'b1;
          credit_d = credit_q - 8'd25;
        end else if (credit_q >= 8'd10) begin
          ret_d_d  = 1'b1;
          credit_d = credit_q - 8'd10;
        end else if (credit_q >= 8'd5) begin
          ret_n_d  = 1'b1;
          credit_d = credit_q - 8'd5;
        end else if (credit_q >= 8'd1) begin
          ret_p_d  = 1'b1;
          credit_d = credit_q - 8'd1;
        end else begin
          credit_d = 8'd0;
        end
        if (credit_d == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_CHANGE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = 8'd0;
      end
    endcase
    busy_d = (state_d == S_DISPENSE) || (state_d == S_CHANGE);
  end

  // State and registered outputs; reset discards any vend or change in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      credit_q   <= 8'd0;
      dispense_q <= 1'b0;
      ret_q_q    <= 1'b0;
      ret_d_q    <= 1'b0;
      ret_n_q    <= 1'b0;
      ret_p_q    <= 1'b0;
      reject_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      dispense_q <= dispense_d;
      ret_q_q    <= ret_q_d;
      ret_d_q    <= ret_d_d;
      ret_n_q    <= ret_n_d;
      ret_p_q    <= ret_p_d;
      reject_q   <= reject_d;
      busy_q     <= busy_d;
    end
  end

  assign credit      = credit_q;
  assign dispense    = dispense_q;
  assign ret_quarter = ret_q_q;
  assign ret_dime    = ret_d_q;
  assign ret_nickel  = ret_n_q;
  assign ret_penny   = ret_p_q;
  assign coin_reject = reject_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: expected pulse events are queued by the
// stimulus and popped by a monitor whenever the DUT raises any pulse output.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       reset, penny, nickel, dime, quarter, select, cancel;
  logic [7:0] credit;
  logic       dispense, ret_quarter, ret_dime, ret_nickel, ret_penny, coin_reject, busy;

  vend_controller #(.PRICE(65), .CREDIT_MAX(200)) dut (
    .clk(clk), .reset(reset),
    .penny(penny), .nickel(nickel), .dime(dime), .quarter(quarter),
    .select(select), .cancel(cancel),
    .credit(credit), .dispense(dispense),
    .ret_quarter(ret_quarter), .ret_dime(ret_dime), .ret_nickel(ret_nickel),
    .ret_penny(ret_penny), .coin_reject(coin_reject), .busy(busy)
  );

  always #5 clk = ~clk;

  // pulse vector order: {dispense, ret_quarter, ret_dime, ret_nickel, ret_penny, coin_reject}
  typedef struct packed {
    logic [5:0] p;
    logic [7:0] c;
    logic       b;
  } exp_t;

  localparam logic [5:0] P_DISP = 6'b100000;
  localparam logic [5:0] P_RQ   = 6'b010000;
  localparam logic [5:0] P_RD   = 6'b001000;
  localparam logic [5:0] P_RN   = 6'b000100;
  localparam logic [5:0] P_RP   = 6'b000010;
  localparam logic [5:0] P_REJ  = 6'b000001;

  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] Q    = 4'b1000;
  localparam logic [3:0] D    = 4'b0100;
  localparam logic [3:0] N    = 4'b0010;
  localparam logic [3:0] P    = 4'b0001;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic [5:0] pulses_s;

  assign pulses_s = {dispense, ret_quarter, ret_dime, ret_nickel, ret_penny, coin_reject};

  // Monitor: every cycle with a pulse must match the oldest expected event.
  always @(negedge clk) begin
    exp_t e;
    if ((|pulses_s) === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse pulses=%b credit=%0d, none required", pulses_s, credit);
      end else begin
        e = sb.pop_front();
        if (pulses_s !== e.p || credit !== e.c || busy !== e.b) begin
          failures++;
          $display("FAIL event pulses=%b credit=%0d busy=%b, required pulses=%b credit=%0d busy=%b",
                   pulses_s, credit, busy, e.p, e.c, e.b);
        end
      end
    end
  end

  task automatic push(input logic [5:0] p, input logic [7:0] c, input logic b);
    exp_t e;
    e.p = p; e.c = c; e.b = b;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic [3:0] coins, input logic s, input logic x, input logic r);
    @(negedge clk);
    {quarter, dime, nickel, penny} = coins;
    select = s; cancel = x; reset = r;
    @(posedge clk);
    #1;
    {quarter, dime, nickel, penny} = NONE;
    select = 1'b0; cancel = 1'b0; reset = 1'b0;
  endtask

  task automatic chk(input string name, input logic [7:0] c, input logic b);
    checks++;
    if (credit !== c || busy !== b) begin
      failures++;
      $display("FAIL %s credit=%0d busy=%b, required credit=%0d busy=%b", name, credit, busy, c, b);
    end
  endtask

  initial begin
    reset = 1'b1; select = 1'b0; cancel = 1'b0;
    {quarter, dime, nickel, penny} = NONE;
    cyc(NONE, 1'b0, 1'b0, 1'b1);
    cyc(Q, 1'b1, 1'b1, 1'b1);
    chk("reset_state", 8'd0, 1'b0);
    checks++;
    if (pulses_s !== 6'b000000) begin
      failures++;
      $display("FAIL reset_pulses got=%b required=000000", pulses_s);
    end

    // three quarters, vend, one dime back
    cyc(Q, 1'b0, 1'b0, 1'b0); chk("q1", 8'd25, 1'b0);
    cyc(Q, 1'b0, 1'b0, 1'b0); chk("q2", 8'd50, 1'b0);
    cyc(Q, 1'b0, 1'b0, 1'b0); chk("q3", 8'd75, 1'b0);
    push(P_DISP, 8'd10, 1'b1);
    cyc(NONE, 1'b1, 1'b0, 1'b0);
    cyc(NONE, 1'b0, 1'b0, 1'b0); chk("disp_to_change", 8'd10, 1'b1);
    push(P_RD, 8'd0, 1'b0);
    cyc(NONE, 1'b0, 1'b0, 1'b0);
    cyc(NONE, 1'b0, 1'b0, 1'b0); chk("vend_done", 8'd0, 1'b0);

    // dime, nickel, penny then cancel
    cyc(D, 1'b0, 1'b0, 1'b0);
    cyc(N, 1'b0, 1'b0, 1'b0);
    cyc(P, 1'b0, 1'b0, 1'b0); chk("credit16", 8'd16, 1'b0);
    cyc(NONE, 1'b0, 1'b1, 1'b0); chk("cancel16", 8'd16, 1'b1);
    push(P_RD, 8'd6, 1'b1);
    push(P_RN, 8'd1, 1'b1);
    push(P_RP, 8'd0, 1'b0);
    repeat (3) cyc(NONE, 1'b0, 1'b0, 1'b0);

    // insufficient credit, then select+cancel together
    cyc(Q, 1'b0, 1'b0, 1'b0);
    cyc(N, 1'b0, 1'b0, 1'b0);
    cyc(D, 1'b0, 1'b0, 1'b0); chk("credit40", 8'd40, 1'b0);
    cyc(NONE, 1'b1, 1'b0, 1'b0); chk("select_low", 8'd40, 1'b0);
    cyc(Q, 1'b0, 1'b0, 1'b0);
    cyc(D, 1'b0, 1'b0, 1'b0); chk("credit75", 8'd75, 1'b0);
    cyc(NONE, 1'b1, 1'b1, 1'b0); chk("sel_cancel", 8'd75, 1'b1);
    push(P_RQ, 8'd50, 1'b1);
    push(P_RQ, 8'd25, 1'b1);
    push(P_RQ, 8'd0, 1'b0);
    repeat (3) cyc(NONE, 1'b0, 1'b0, 1'b0);

    // credit ceiling
    repeat (7) cyc(Q, 1'b0, 1'b0, 1'b0);
    cyc(D, 1'b0, 1'b0, 1'b0);
    cyc(N, 1'b0, 1'b0, 1'b0); chk("credit190", 8'd190, 1'b0);
    push(P_REJ, 8'd190, 1'b0);
    cyc(Q, 1'b0, 1'b0, 1'b0);
    push(P_REJ, 8'd190, 1'b0);
    cyc(D | N, 1'b0, 1'b0, 1'b0); chk("multi_coin", 8'd190, 1'b0);
    cyc(D, 1'b0, 1'b0, 1'b0); chk("credit_max", 8'd200, 1'b0);
    push(P_REJ, 8'd200, 1'b0);
    cyc(P, 1'b0, 1'b0, 1'b0);
    push(P_DISP, 8'd135, 1'b1);
    cyc(NONE, 1'b1, 1'b0, 1'b0);
    cyc(NONE, 1'b0, 1'b0, 1'b0); chk("change135", 8'd135, 1'b1);
    push(P_RQ, 8'd110, 1'b1);
    push(P_RQ, 8'd85, 1'b1);
    push(P_RQ, 8'd60, 1'b1);
    push(P_RQ, 8'd35, 1'b1);
    push(P_RQ, 8'd10, 1'b1);
    push(P_RD, 8'd0, 1'b0);
    repeat (6) cyc(NONE, 1'b0, 1'b0, 1'b0);

    // coins while busy are rejected without disturbing the sequence
    repeat (3) cyc(Q, 1'b0, 1'b0, 1'b0);
    push(P_DISP, 8'd10, 1'b1);
    cyc(NONE, 1'b1, 1'b0, 1'b0);
    push(P_REJ, 8'd10, 1'b1);
    cyc(Q, 1'b1, 1'b1, 1'b0);
    push(P_RD | P_REJ, 8'd0, 1'b0);
    cyc(Q, 1'b0, 1'b0, 1'b0);
    cyc(NONE, 1'b0, 1'b0, 1'b0); chk("busy_coin_done", 8'd0, 1'b0);

    // reset in the middle of change
    cyc(Q, 1'b0, 1'b0, 1'b0);
    cyc(Q, 1'b0, 1'b0, 1'b0);
    cyc(D, 1'b0, 1'b0, 1'b0);
    cyc(NONE, 1'b0, 1'b1, 1'b0); chk("cancel60", 8'd60, 1'b1);
    push(P_RQ, 8'd35, 1'b1);
    cyc(NONE, 1'b0, 1'b0, 1'b0); chk("mid_change35", 8'd35, 1'b1);
    cyc(Q, 1'b1, 1'b1, 1'b1); chk("reset_mid_change", 8'd0, 1'b0);
    repeat (4) cyc(NONE, 1'b0, 1'b0, 1'b0);
    chk("after_reset", 8'd0, 1'b0);

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL missing_events pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
